plate_overlay_sequencer: RTL and testbench

// Frame-level controller that feeds the plate-overlay/char-display stage. Validates per-frame plate

---
 rtl/plate_overlay_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_plate_overlay_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/plate_overlay_sequencer.sv
// plate_overlay_sequencer
// Frame-level controller for the plate-overlay stage. It validates per-frame
// recognition results, requires STABLE_FRAMES identical results before it
// commits them, and commits only on a frame boundary so the overlay never
// tears. It also handles the three user keys: mode step, freeze and clear.
//
// Optional feature: define OVL_SEQ_DEBOUNCE_EN to add a DEB_CYCLES debounce
// counter per key. Without it, the synchronised key level is used directly.
//
// Handshake: res_valid is a 1-cycle strobe with no back-pressure. When it is
// high, res_* are sampled in that cycle. A strobe that coincides with the
// frame boundary, or that arrives while that boundary is being processed,
// belongs to the new frame.
module plate_overlay_sequencer #(
  parameter int unsigned STABLE_FRAMES = 3,
  parameter int unsigned HOLD_FRAMES   = 30,
  parameter int unsigned DEB_CYCLES    = 250000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_vs,
  input  logic [2:0]  key,
  input  logic        res_valid,
  input  logic [71:0] res_lines,
  input  logic [11:0] res_up,
  input  logic [11:0] res_down,
  input  logic [19:0] res_digits,
  output logic [71:0] disp_lines,
  output logic [11:0] disp_up,
  output logic [11:0] disp_down,
  output logic [19:0] disp_digits,
  output logic        disp_valid,
  output logic [1:0]  ovl_mode,
  output logic        frozen,
  output logic [15:0] frame_cnt,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {S_WAIT = 2'd0, S_CHECK = 2'd1, S_COMMIT = 2'd2} state_t;

  localparam logic [3:0] STABLE_MAX = 4'(STABLE_FRAMES);
  localparam logic [7:0] HOLD_MAX   = 8'(HOLD_FRAMES);

  state_t state, state_nxt;
  logic        vs_d, fb;
  logic [2:0]  k_s1, k_s2, k_clean, k_clean_d, press;
  logic        cand_ok, pend_ok, cand_good, frame_end, busy, same_digits;
  logic [71:0] cand_lines, pend_lines;
  logic [11:0] cand_up, cand_down, pend_up, pend_down;
  logic [19:0] cand_digits, pend_digits, prev_digits;
  logic [3:0]  match_cnt, match_calc;
  logic [7:0]  miss_cnt, miss_calc;

  assign dbg_state = state;

  // Frame boundary: rising edge of i_vs against its registered copy.
  always_ff @(posedge clk) begin
    if (rst) vs_d <= 1'b1;
    else     vs_d <= i_vs;
  end
  assign fb = i_vs & ~vs_d;

  // Two-flop key synchroniser; keys idle high.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_s1 <= 3'b111;
      k_s2 <= 3'b111;
    end else begin
      k_s1 <= key;
      k_s2 <= k_s1;
    end
  end

`ifdef OVL_SEQ_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
  logic [CW-1:0] deb_cnt [3];
  logic [2:0]    k_acc;
  // Accept a new key level only after DEB_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_acc <= 3'b111;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (k_s2[i] != k_acc[i]) begin
          if (deb_cnt[i] == CW'(DEB_CYCLES - 1)) begin
            k_acc[i]   <= k_s2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end
  assign k_clean = k_acc;
`else
  logic unused_deb;
  assign unused_deb = (DEB_CYCLES == 0);
  assign k_clean    = k_s2;
`endif

  // Delayed clean level; a press is the high-to-low edge of the clean level.
  always_ff @(posedge clk) begin
    if (rst) k_clean_d <= 3'b111;
    else     k_clean_d <= k_clean;
  end
  assign press = k_clean_d & ~k_clean;

  // Candidate checks (strict line order, band order, BCD digits) and counter updates.
  always_comb begin
    cand_good = cand_ok && (cand_up < cand_down);
    for (int i = 0; i < 5; i++) begin
      if (cand_lines[i*12 +: 12] >= cand_lines[(i+1)*12 +: 12]) cand_good = 1'b0;
    end
    for (int i = 0; i < 5; i++) begin
      if (cand_digits[i*4 +: 4] > 4'd9) cand_good = 1'b0;
    end
    same_digits = (cand_digits == prev_digits);
    match_calc  = 4'd0;
    if (cand_good) begin
      if (!same_digits)               match_calc = 4'd1;
      else if (match_cnt >= STABLE_MAX) match_calc = STABLE_MAX;
      else                            match_calc = match_cnt + 4'd1;
    end
    miss_calc = (miss_cnt == 8'hFF) ? 8'hFF : miss_cnt + 8'd1;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_WAIT;
    else     state <= state_nxt;
  end

  // FSM next state; a clear press always returns to WAIT.
  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT:   if (fb) state_nxt = S_CHECK;
      S_CHECK:  state_nxt = (cand_good && match_calc == STABLE_MAX && !frozen) ? S_COMMIT : S_WAIT;
      S_COMMIT: state_nxt = S_WAIT;
      default:  state_nxt = S_WAIT;
    endcase
    if (press[2]) state_nxt = S_WAIT;
  end

  assign busy      = fb || (state != S_WAIT);
  assign frame_end = (state == S_COMMIT) || (state == S_CHECK && state_nxt == S_WAIT);

  // Result capture: cand holds the current frame, pend holds an early next-frame result.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_ok <= 1'b0; pend_ok <= 1'b0;
      cand_lines <= '0; cand_up <= '0; cand_down <= '0; cand_digits <= '0;
      pend_lines <= '0; pend_up <= '0; pend_down <= '0; pend_digits <= '0;
    end else if (press[2]) begin
      cand_ok <= 1'b0;
      pend_ok <= 1'b0;
    end else if (frame_end) begin
      pend_ok <= 1'b0;
      if (res_valid) begin
        cand_lines <= res_lines; cand_up <= res_up; cand_down <= res_down; cand_digits <= res_digits;
        cand_ok    <= 1'b1;
      end else begin
        cand_lines <= pend_lines; cand_up <= pend_up; cand_down <= pend_down; cand_digits <= pend_digits;
        cand_ok    <= pend_ok;
      end
    end else if (res_valid) begin
      if (busy) begin
        pend_lines <= res_lines; pend_up <= res_up; pend_down <= res_down; pend_digits <= res_digits;
        pend_ok    <= 1'b1;
      end else begin
        cand_lines <= res_lines; cand_up <= res_up; cand_down <= res_down; cand_digits <= res_digits;
        cand_ok    <= 1'b1;
      end
    end
  end

  // Stability/miss counters, display registers, freeze and mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_cnt <= '0; miss_cnt <= '0; prev_digits <= '0;
      disp_lines <= '0; disp_up <= '0; disp_down <= '0; disp_digits <= '0;
      disp_valid <= 1'b0; frozen <= 1'b0; ovl_mode <= 2'd2; frame_cnt <= '0;
    end else begin
      if (fb)       frame_cnt <= frame_cnt + 16'd1;
      if (press[0]) ovl_mode  <= ovl_mode + 2'd1;
      if (press[2]) begin
        disp_valid <= 1'b0;
        match_cnt  <= '0;
        miss_cnt   <= '0;
        frozen     <= 1'b0;
      end else begin
        if (press[1]) frozen <= ~frozen;
        if (state == S_CHECK) begin
          match_cnt <= match_calc;
          if (cand_good) begin
            miss_cnt <= '0;
            if (!same_digits) prev_digits <= cand_digits;
          end else begin
            miss_cnt <= miss_calc;
            if (miss_calc >= HOLD_MAX && !frozen) disp_valid <= 1'b0;
          end
        end else if (state == S_COMMIT) begin
          disp_lines  <= cand_lines;
          disp_up     <= cand_up;
          disp_down   <= cand_down;
          disp_digits <= cand_digits;
          disp_valid  <= 1'b1;
          miss_cnt    <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_plate_overlay_sequencer.sv
// Directed bench for plate_overlay_sequencer with default parameters
// (STABLE_FRAMES=3, HOLD_FRAMES=30, debounce disabled).
module tb_plate_overlay_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_vs = 1'b1;
  logic [2:0]  key = 3'b111;
  logic        res_valid = 1'b0;
  logic [71:0] res_lines = '0;
  logic [11:0] res_up = '0, res_down = '0;
  logic [19:0] res_digits = '0;
  logic [71:0] disp_lines;
  logic [11:0] disp_up, disp_down;
  logic [19:0] disp_digits;
  logic        disp_valid, frozen;
  logic [1:0]  ovl_mode, dbg_state;
  logic [15:0] frame_cnt;

  localparam logic [71:0] L_GOOD = {12'd250, 12'd220, 12'd190, 12'd160, 12'd130, 12'd100};
  localparam logic [71:0] L_BAD  = {12'd250, 12'd220, 12'd190, 12'd130, 12'd130, 12'd100};
  localparam logic [11:0] UP = 12'd40, DN = 12'd80;
  localparam logic [19:0] D1 = 20'h54321, D2 = 20'h64321, DA = 20'hA4321;

  int n_checks = 0;
  int n_errors = 0;

  plate_overlay_sequencer dut (
    .clk(clk), .rst(rst), .i_vs(i_vs), .key(key), .res_valid(res_valid),
    .res_lines(res_lines), .res_up(res_up), .res_down(res_down), .res_digits(res_digits),
    .disp_lines(disp_lines), .disp_up(disp_up), .disp_down(disp_down),
    .disp_digits(disp_digits), .disp_valid(disp_valid), .ovl_mode(ovl_mode),
    .frozen(frozen), .frame_cnt(frame_cnt), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; i_vs = 1'b1; key = 3'b111; res_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_res(input logic [71:0] l, input logic [11:0] u, input logic [11:0] d,
                         input logic [19:0] g);
    res_lines = l; res_up = u; res_down = d; res_digits = g;
  endtask

  task automatic send(input logic [71:0] l, input logic [11:0] u, input logic [11:0] d,
                      input logic [19:0] g);
    @(negedge clk);
    set_res(l, u, d, g);
    res_valid = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  // Drop i_vs and raise it again; returns at the negedge where i_vs rises.
  task automatic vs_rise();
    @(negedge clk);
    i_vs = 1'b0;
    repeat (3) @(negedge clk);
    i_vs = 1'b1;
  endtask

  task automatic frame();
    vs_rise();
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_res(input logic [19:0] g);
    send(L_GOOD, UP, DN, g);
    frame();
  endtask

  task automatic press_key(input int idx);
    @(negedge clk);
    key[idx] = 1'b0;
    repeat (4) @(negedge clk);
    key[idx] = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  logic [71:0] bad_l [3];
  logic [11:0] bad_u [3];
  logic [19:0] bad_g [3];

  initial begin
    bad_l[0] = L_BAD;  bad_u[0] = UP; bad_g[0] = D1;
    bad_l[1] = L_GOOD; bad_u[1] = UP; bad_g[1] = DA;
    bad_l[2] = L_GOOD; bad_u[2] = DN; bad_g[2] = D1;

    // Reset state
    do_reset();
    check("rst_valid", 72'(disp_valid), 72'(0));
    check("rst_digits", 72'(disp_digits), 72'(0));
    check("rst_mode", 72'(ovl_mode), 72'(2));
    check("rst_frozen", 72'(frozen), 72'(0));
    check("rst_frame_cnt", 72'(frame_cnt), 72'(0));

    // Three stable frames: commit exactly two cycles after the third rise
    frame_res(D1);
    frame_res(D1);
    send(L_GOOD, UP, DN, D1);
    vs_rise();
    repeat (2) @(negedge clk);
    check("commit_early", 72'(disp_valid), 72'(0));
    @(negedge clk);
    check("commit_valid", 72'(disp_valid), 72'(1));
    check("commit_digits", 72'(disp_digits), 72'(D1));
    check("commit_lines", disp_lines, L_GOOD);
    check("commit_up", 72'(disp_up), 72'(UP));
    check("commit_down", 72'(disp_down), 72'(DN));
    repeat (2) @(negedge clk);

    // Digit change restarts stability counting
    do_reset();
    frame_res(D1);
    frame_res(D1);
    frame_res(D2);
    frame_res(D2);
    check("change_no_commit", 72'(disp_valid), 72'(0));
    frame_res(D2);
    check("change_valid", 72'(disp_valid), 72'(1));
    check("change_digits", 72'(disp_digits), 72'(D2));
    check("frame_cnt5", 72'(frame_cnt), 72'(5));

    // Hold: 30 empty frames drop disp_valid, data retained
    repeat (29) frame();
    check("hold_29", 72'(disp_valid), 72'(1));
    frame();
    check("hold_30", 72'(disp_valid), 72'(0));
    check("hold_digits", 72'(disp_digits), 72'(D2));
    check("frame_cnt35", 72'(frame_cnt), 72'(35));

    // Invalid candidates never commit: bad lines, digit A, up == down
    for (int v = 0; v < 3; v++) begin
      do_reset();
      repeat (5) begin
        send(bad_l[v], bad_u[v], DN, bad_g[v]);
        frame();
      end
      check($sformatf("bad%0d_valid", v), 72'(disp_valid), 72'(0));
      check($sformatf("bad%0d_digits", v), 72'(disp_digits), 72'(0));
    end

    // Freeze blocks commit; release commits on the next boundary
    do_reset();
    repeat (3) frame_res(D1);
    check("frz_pre_valid", 72'(disp_valid), 72'(1));
    press_key(1);
    check("frz_on", 72'(frozen), 72'(1));
    repeat (3) frame_res(D2);
    check("frz_digits_held", 72'(disp_digits), 72'(D1));
    press_key(1);
    check("frz_off", 72'(frozen), 72'(0));
    frame_res(D2);
    check("frz_release_digits", 72'(disp_digits), 72'(D2));

    // Result on the boundary cycle belongs to the next frame
    do_reset();
    frame_res(D1);
    frame_res(D1);
    set_res(L_GOOD, UP, DN, D1);
    vs_rise();
    res_valid = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("simul_not_current", 72'(disp_valid), 72'(0));
    frame();
    frame_res(D1);
    check("simul_not_yet", 72'(disp_valid), 72'(0));
    frame_res(D1);
    check("simul_pend_used", 72'(disp_valid), 72'(1));

    // Clear during COMMIT wins
    do_reset();
    frame_res(D1);
    frame_res(D1);
    send(L_GOOD, UP, DN, D1);
    vs_rise();
    key[2] = 1'b0;
    repeat (3) @(negedge clk);
    check("clr_commit_valid", 72'(disp_valid), 72'(0));
    key[2] = 1'b1;
    repeat (4) @(negedge clk);
    press_key(1);
    check("clr_frz_on", 72'(frozen), 72'(1));
    press_key(2);
    check("clr_frz_off", 72'(frozen), 72'(0));

    // Mode stepping 2 -> 3 -> 0 -> 1
    do_reset();
    press_key(0);
    check("mode_1press", 72'(ovl_mode), 72'(3));
    press_key(0);
    press_key(0);
    check("mode_3press", 72'(ovl_mode), 72'(1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
